// File: rtl/seq_mag_comparator.sv
// seq_mag_comparator: digit-serial magnitude comparator.
// Compares two WIDTH-bit operands MSB-first, DIGIT bits per clock, over
// N = WIDTH/DIGIT cycles. Supports unsigned and two's-complement order and
// an output enable on the result flags.
// Optional feature: define SEQ_CMP_MINMAX_EN to add registered max_out/min_out.
//
// Handshake: ready is high in IDLE and DONE. A request is accepted on any
// rising edge where ready && start; a, b and signed_mode are captured on that
// same edge. busy is high while digits are being compared. done pulses for
// exactly one cycle, and the result flags change only on the edge that raises
// done. start while busy is ignored.
module seq_mag_comparator #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    input  logic             en,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic             equal,
    output logic             lesser,
    output logic             greater,
`ifdef SEQ_CMP_MINMAX_EN
    output logic [WIDTH-1:0] max_out,
    output logic [WIDTH-1:0] min_out,
`endif
    output logic [1:0]       dbg_state
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [CW-1:0]    r_count;
    logic             r_gt;
    logic             r_lt;
    logic             r_eq_res;
    logic             r_lt_res;
    logic             r_gt_res;

    logic             w_accept;
    logic             w_last;
    logic [DIGIT-1:0] w_dig_a;
    logic [DIGIT-1:0] w_dig_b;
    logic             w_gt_nxt;
    logic             w_lt_nxt;
    logic [WIDTH-1:0] w_a_xf;
    logic [WIDTH-1:0] w_b_xf;

`ifdef SEQ_CMP_MINMAX_EN
    logic [WIDTH-1:0] r_a_orig;
    logic [WIDTH-1:0] r_b_orig;
    logic [WIDTH-1:0] r_max;
    logic [WIDTH-1:0] r_min;
`endif

    // Handshake decode and digit-compare datapath
    always_comb begin
        ready     = (r_state == S_IDLE) || (r_state == S_DONE);
        busy      = (r_state == S_RUN);
        done      = (r_state == S_DONE);
        dbg_state = r_state;
        w_accept  = ready && start;
        w_last    = (r_state == S_RUN) && (r_count == '0);
        w_dig_a   = r_a_sh[WIDTH-1 -: DIGIT];
        w_dig_b   = r_b_sh[WIDTH-1 -: DIGIT];
        // Once a digit has differed the decision is frozen.
        w_gt_nxt  = r_gt | (~r_gt & ~r_lt & (w_dig_a > w_dig_b));
        w_lt_nxt  = r_lt | (~r_gt & ~r_lt & (w_dig_a < w_dig_b));
        // Offset-binary: flipping the sign bit maps signed order onto unsigned order.
        w_a_xf    = {a[WIDTH-1] ^ signed_mode, a[WIDTH-2:0]};
        w_b_xf    = {b[WIDTH-1] ^ signed_mode, b[WIDTH-2:0]};
        equal     = r_eq_res & en;
        lesser    = r_lt_res & en;
        greater   = r_gt_res & en;
    end

    // Next-state logic for IDLE -> RUN -> DONE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_RUN;
            S_RUN:   if (r_count == '0) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = start ? S_RUN : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Operand shift registers, decision flags and cycle counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_count <= '0;
            r_gt    <= 1'b0;
            r_lt    <= 1'b0;
        end else if (w_accept) begin
            r_a_sh  <= w_a_xf;
            r_b_sh  <= w_b_xf;
            r_count <= CW'(N - 1);
            r_gt    <= 1'b0;
            r_lt    <= 1'b0;
        end else if (r_state == S_RUN) begin
            r_a_sh  <= r_a_sh << DIGIT;
            r_b_sh  <= r_b_sh << DIGIT;
            r_gt    <= w_gt_nxt;
            r_lt    <= w_lt_nxt;
            if (r_count != '0) r_count <= r_count - 1'b1;
        end
    end

    // Result flags: loaded on the RUN->DONE edge, held otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_eq_res <= 1'b0;
            r_lt_res <= 1'b0;
            r_gt_res <= 1'b0;
        end else if (w_last) begin
            r_eq_res <= ~w_gt_nxt & ~w_lt_nxt;
            r_lt_res <= w_lt_nxt;
            r_gt_res <= w_gt_nxt;
        end
    end

`ifdef SEQ_CMP_MINMAX_EN
    // Untransformed operand copies and max/min results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_orig <= '0;
            r_b_orig <= '0;
            r_max    <= '0;
            r_min    <= '0;
        end else begin
            if (w_accept) begin
                r_a_orig <= a;
                r_b_orig <= b;
            end
            if (w_last) begin
                r_max <= w_gt_nxt ? r_a_orig : r_b_orig;
                r_min <= w_gt_nxt ? r_b_orig : r_a_orig;
            end
        end
    end

    assign max_out = r_max;
    assign min_out = r_min;
`endif

endmodule
